// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: operation select codes and status flags.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_TFR  = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUBB = 3'b010,
    OP_DEC  = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_XOR  = 3'b110,
    OP_NOT  = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic cout;
    logic zero;
    logic neg;
    logic ovf;
  } alu_flags_t;

  // Ops with the top select bit set are bitwise and never produce carry or overflow
  function automatic logic is_logic_op(input logic [2:0] sel);
    return sel[2];
  endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Operation/result handshake bundle between the sequencer, alu_pipe and the consumer.
interface alu_pipe_if #(parameter int WIDTH = 8) ();

  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic [2:0]       i_sel;
  logic             i_Cin;
  logic             i_use_acc;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_G;
  logic             o_Cout;
  logic             o_zero;
  logic             o_neg;
  logic             o_ovf;
  logic [WIDTH-1:0] o_acc;

  modport master (
    output i_valid, i_a, i_b, i_sel, i_Cin, i_use_acc, i_ready,
    input  o_ready, o_valid, o_G, o_Cout, o_zero, o_neg, o_ovf, o_acc
  );

  modport slave (
    input  i_valid, i_a, i_b, i_sel, i_Cin, i_use_acc, i_ready,
    output o_ready, o_valid, o_G, o_Cout, o_zero, o_neg, o_ovf, o_acc
  );

endinterface

// File: rtl/alu_core.sv
// Combinational WIDTH-bit ALU: every arithmetic op is A + opb + Cin with opb chosen by select.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  input  logic             cin,
  output logic [WIDTH-1:0] g,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] opb_s;
  logic [WIDTH-1:0] logic_s;
  logic [WIDTH:0]   sum_s;

  // Second addend for arithmetic ops, bitwise result for logic ops
  always_comb begin
    opb_s   = {WIDTH{1'b0}};
    logic_s = {WIDTH{1'b0}};
    case (alu_op_e'(sel))
      OP_TFR:  opb_s   = {WIDTH{1'b0}};
      OP_ADD:  opb_s   = b;
      OP_SUBB: opb_s   = ~b;
      OP_DEC:  opb_s   = {WIDTH{1'b1}};
      OP_AND:  logic_s = a & b;
      OP_OR:   logic_s = a | b;
      OP_XOR:  logic_s = a ^ b;
      OP_NOT:  logic_s = ~a;
      default: begin
        opb_s   = {WIDTH{1'b0}};
        logic_s = {WIDTH{1'b0}};
      end
    endcase
  end

  assign sum_s = {1'b0, a} + {1'b0, opb_s} + {{WIDTH{1'b0}}, cin};

  // Result mux; overflow compares operand signs against the result sign
  always_comb begin
    g    = {WIDTH{1'b0}};
    cout = 1'b0;
    ovf  = 1'b0;
    if (is_logic_op(sel)) begin
      g    = logic_s;
      cout = 1'b0;
      ovf  = 1'b0;
    end else begin
      g    = sum_s[WIDTH-1:0];
      cout = sum_s[WIDTH];
      ovf  = (a[WIDTH-1] == opb_s[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: stage 1 holds the operation, stage 2 the registered
// result and flags. The accumulator is read and written at stage-1 advance, so chains need no stall.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic       i_clk,
  input logic       i_rst,
  alu_pipe_if.slave bus
);

  logic             s1_valid_r;
  logic [WIDTH-1:0] s1_a_r;
  logic [WIDTH-1:0] s1_b_r;
  logic [2:0]       s1_sel_r;
  logic             s1_cin_r;
  logic             s1_use_acc_r;

  logic             s2_valid_r;
  logic [WIDTH-1:0] g_r;
  alu_flags_t       flags_r;
  logic [WIDTH-1:0] acc_r;

  logic             adv2_s;
  logic             accept_s;
  logic [WIDTH-1:0] op_a_s;
  logic [WIDTH-1:0] core_g_s;
  logic             core_cout_s;
  logic             core_ovf_s;

  assign adv2_s      = s1_valid_r && (!s2_valid_r || bus.i_ready);
  assign bus.o_ready = !s1_valid_r || adv2_s;
  assign accept_s    = bus.i_valid && bus.o_ready;
  assign op_a_s      = s1_use_acc_r ? acc_r : s1_a_r;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a    (op_a_s),
    .b    (s1_b_r),
    .sel  (s1_sel_r),
    .cin  (s1_cin_r),
    .g    (core_g_s),
    .cout (core_cout_s),
    .ovf  (core_ovf_s)
  );

  // Stage 1: capture an accepted operation, empty when it moves on without a replacement
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_r   <= 1'b0;
      s1_a_r       <= {WIDTH{1'b0}};
      s1_b_r       <= {WIDTH{1'b0}};
      s1_sel_r     <= 3'b000;
      s1_cin_r     <= 1'b0;
      s1_use_acc_r <= 1'b0;
    end else if (accept_s) begin
      s1_valid_r   <= 1'b1;
      s1_a_r       <= bus.i_a;
      s1_b_r       <= bus.i_b;
      s1_sel_r     <= bus.i_sel;
      s1_cin_r     <= bus.i_Cin;
      s1_use_acc_r <= bus.i_use_acc;
    end else if (adv2_s) begin
      s1_valid_r   <= 1'b0;
    end
  end

  // Stage 2 and accumulator: load together on advance, drop valid after an output handshake
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s2_valid_r <= 1'b0;
      g_r        <= {WIDTH{1'b0}};
      flags_r    <= '{cout: 1'b0, zero: 1'b0, neg: 1'b0, ovf: 1'b0};
      acc_r      <= {WIDTH{1'b0}};
    end else if (adv2_s) begin
      s2_valid_r <= 1'b1;
      g_r        <= core_g_s;
      flags_r    <= '{cout: core_cout_s,
                      zero: (core_g_s == {WIDTH{1'b0}}),
                      neg:  core_g_s[WIDTH-1],
                      ovf:  core_ovf_s};
      acc_r      <= core_g_s;
    end else if (bus.i_ready) begin
      s2_valid_r <= 1'b0;
    end
  end

  assign bus.o_valid = s2_valid_r;
  assign bus.o_G     = g_r;
  assign bus.o_Cout  = flags_r.cout;
  assign bus.o_zero  = flags_r.zero;
  assign bus.o_neg   = flags_r.neg;
  assign bus.o_ovf   = flags_r.ovf;
  assign bus.o_acc   = acc_r;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at WIDTH=8: directed sweeps, accumulator chain, backpressure,
// mid-stream reset and a random valid/ready regression against an integer reference model.
module tb_alu_pipe;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(W)) bus ();

  alu_pipe #(.WIDTH(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] g;
    logic [3:0]   flags;
    int           cyc;
  } exp_t;

  exp_t         sb_q[$];
  logic [W-1:0] obs_g[$];
  logic [3:0]   obs_f[$];
  logic [W-1:0] model_acc;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n_in, n_out, first_out, last_out;
  bit check_lat = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: unsigned integer sum for G/Cout, signed range test for overflow
  function automatic exp_t ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [2:0] sel, input logic cin);
    exp_t e;
    int ua, ub, us, sa, sb, ss;
    logic [W-1:0] g;
    logic ovf;
    e.cyc = 0;
    if (sel[2]) begin
      case (sel[1:0])
        2'd0:    g = a & b;
        2'd1:    g = a | b;
        2'd2:    g = a ^ b;
        default: g = ~a;
      endcase
      e.g     = g;
      e.flags = {1'b0, (g == '0), g[W-1], 1'b0};
    end else begin
      case (sel[1:0])
        2'd0:    ub = 0;
        2'd1:    ub = int'(b);
        2'd2:    ub = (1 << W) - 1 - int'(b);
        default: ub = (1 << W) - 1;
      endcase
      ua  = int'(a);
      us  = ua + ub + int'(cin);
      g   = us[W-1:0];
      sa  = (ua >= (1 << (W-1))) ? ua - (1 << W) : ua;
      sb  = (ub >= (1 << (W-1))) ? ub - (1 << W) : ub;
      ss  = sa + sb + int'(cin);
      ovf = (ss > (1 << (W-1)) - 1) || (ss < -(1 << (W-1)));
      e.g     = g;
      e.flags = {(us >= (1 << W)), (g == '0), g[W-1], ovf};
    end
    return e;
  endfunction

  // One clock: drive at negedge, predict handshakes, score the output, push the new expectation
  task automatic step(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2:0] sel, input logic cin, input logic use_acc, input bit rdy);
    exp_t e;
    bit in_hs, out_hs;
    @(negedge clk);
    bus.i_valid   = v;
    bus.i_a       = a;
    bus.i_b       = b;
    bus.i_sel     = sel;
    bus.i_Cin     = cin;
    bus.i_use_acc = use_acc;
    bus.i_ready   = rdy;
    #1;
    out_hs = bus.o_valid && rdy;
    in_hs  = v && bus.o_ready;
    if (out_hs) begin
      obs_g.push_back(bus.o_G);
      obs_f.push_back({bus.o_Cout, bus.o_zero, bus.o_neg, bus.o_ovf});
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
      n_out++;
      check_eq("sb_nonempty", (sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check_eq("G", bus.o_G, e.g);
        check_eq("flags", {bus.o_Cout, bus.o_zero, bus.o_neg, bus.o_ovf}, e.flags);
        check_eq("acc", bus.o_acc, e.g);
        if (check_lat) check_eq("latency", cyc - e.cyc, 2);
      end
    end
    if (in_hs) begin
      e     = ref_alu(use_acc ? model_acc : a, b, sel, cin);
      e.cyc = cyc;
      sb_q.push_back(e);
      model_acc = e.g;
      n_in++;
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_a     = W'($urandom);
    bus.i_b     = W'($urandom);
    bus.i_ready = 1'b1;
    @(negedge clk);
    rst         = 1'b0;
    bus.i_valid = 1'b0;
    #1;
    check_eq("rst_valid", bus.o_valid, 0);
    check_eq("rst_acc", bus.o_acc, 0);
    check_eq("rst_ready", bus.o_ready, 1);
    check_eq("rst_G", bus.o_G, 0);
    sb_q.delete();
    model_acc = '0;
    cyc++;
  endtask

  task automatic clear_obs();
    obs_g.delete();
    obs_f.delete();
    n_in      = 0;
    n_out     = 0;
    first_out = -1;
    last_out  = -1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 3'b000, 1'b0, 1'b0, 1'b1);
  endtask

  logic [W-1:0] g_hold;
  logic [3:0]   f_hold;
  logic [W-1:0] ra, rb;
  logic [2:0]   rsel;

  initial begin
    rst           = 1'b1;
    bus.i_valid   = 1'b0;
    bus.i_a       = '0;
    bus.i_b       = '0;
    bus.i_sel     = 3'b000;
    bus.i_Cin     = 1'b0;
    bus.i_use_acc = 1'b0;
    bus.i_ready   = 1'b1;
    model_acc     = '0;
    clear_obs();
    repeat (2) @(posedge clk);
    do_reset();

    // Sweep all 16 {sel,Cin} with A=all ones, B=1
    clear_obs();
    check_lat = 1'b1;
    for (int k = 0; k < 16; k++) step(1'b1, 8'hFF, 8'h01, k[3:1], k[0], 1'b0, 1'b1);
    drain(3);
    check_lat = 1'b0;
    check_eq("sweep_cnt", obs_g.size(), 16);
    if (obs_g.size() == 16) begin
      check_eq("add_G", obs_g[2], 8'h00);   check_eq("add_F", obs_f[2], 4'b1100);
      check_eq("sub_G", obs_g[5], 8'hFE);   check_eq("sub_F", obs_f[5], 4'b1010);
      check_eq("dec_G", obs_g[6], 8'hFE);   check_eq("dec_F", obs_f[6], 4'b1010);
      check_eq("inc_G", obs_g[1], 8'h00);   check_eq("inc_F", obs_f[1], 4'b1100);
      check_eq("not0_G", obs_g[14], 8'h00); check_eq("not0_F", obs_f[14], 4'b0100);
      check_eq("not1_G", obs_g[15], 8'h00); check_eq("not1_F", obs_f[15], 4'b0100);
    end

    // Signed overflow: max positive + 1
    clear_obs();
    step(1'b1, 8'h7F, 8'h01, 3'b001, 1'b0, 1'b0, 1'b1);
    drain(3);
    check_eq("ovf_cnt", obs_g.size(), 1);
    if (obs_g.size() == 1) begin
      check_eq("ovf_G", obs_g[0], 8'h80);
      check_eq("ovf_F", obs_f[0], 4'b0011);
    end

    // Accumulate chain from zero, back to back, with junk on i_a
    do_reset();
    clear_obs();
    for (int k = 0; k < 4; k++) step(1'b1, 8'h55, 8'h03, 3'b001, 1'b0, 1'b1, 1'b1);
    drain(3);
    check_eq("chain_cnt", n_out, 4);
    check_eq("chain_span", last_out - first_out, 3);
    if (obs_g.size() == 4) begin
      check_eq("chain0", obs_g[0], 8'h03);
      check_eq("chain1", obs_g[1], 8'h06);
      check_eq("chain2", obs_g[2], 8'h09);
      check_eq("chain3", obs_g[3], 8'h0C);
    end
    check_eq("chain_acc", bus.o_acc, 8'h0C);

    // Backpressure: continuous input with the consumer stalled for 5 cycles
    clear_obs();
    for (int k = 0; k < 5; k++) begin
      step(1'b1, W'($urandom), W'($urandom), 3'(k), 1'b1, 1'b0, 1'b0);
      if (k == 2) begin
        g_hold = bus.o_G;
        f_hold = {bus.o_Cout, bus.o_zero, bus.o_neg, bus.o_ovf};
        check_eq("bp_valid", bus.o_valid, 1);
      end else if (k > 2) begin
        check_eq("bp_hold_G", bus.o_G, g_hold);
        check_eq("bp_hold_F", {bus.o_Cout, bus.o_zero, bus.o_neg, bus.o_ovf}, f_hold);
      end
    end
    check_eq("bp_accepted", n_in, 2);
    check_eq("bp_ready", bus.o_ready, 0);
    drain(4);
    check_eq("bp_retired", n_out, 2);
    check_eq("bp_sb_empty", sb_q.size(), 0);

    // Reset with both stages full, then no stale result may appear
    clear_obs();
    for (int k = 0; k < 3; k++) step(1'b1, 8'h10, 8'h20, 3'b001, 1'b0, 1'b0, 1'b0);
    check_eq("mid_full", bus.o_ready, 0);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1'b0, '0, '0, 3'b000, 1'b0, 1'b0, 1'b1);
      check_eq("stale_valid", bus.o_valid, 0);
    end

    // Random regression with random valid/ready and accumulator use
    clear_obs();
    for (int k = 0; k < 3000; k++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rsel = 3'($urandom);
      step(($urandom % 4) != 0, ra, rb, rsel, 1'($urandom), 1'($urandom), ($urandom % 4) != 0);
    end
    drain(4);
    check_eq("rand_sb_empty", sb_q.size(), 0);
    check_eq("rand_count", n_out, n_in);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the 4-bit combinational ALU. Same 3-bit select plus carry-in operation encoding, generalised to WIDTH bits.
- Adds a two-stage registered datapath with valid/ready handshakes on both sides, status flags, and an internal accumulator that can replace operand A.
- Sits between a sequencer or register file and a downstream consumer; results retire strictly in issue order.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2).

Ports:
- i_clk  in  1  clock, all state updates on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_valid  in  1  input operation valid
- o_ready  out  1  block can accept an operation this cycle
- i_a  in  WIDTH  operand A
- i_b  in  WIDTH  operand B
- i_sel  in  3  operation select
- i_Cin  in  1  carry in
- i_use_acc  in  1  1: use accumulator in place of i_a
- o_valid  out  1  result valid
- i_ready  in  1  consumer accepts result
- o_G  out  WIDTH  result
- o_Cout  out  1  carry out
- o_zero  out  1  o_G == 0
- o_neg  out  1  o_G[WIDTH-1]
- o_ovf  out  1  signed overflow
- o_acc  out  WIDTH  current accumulator value

Behaviour:
- Reset (i_rst sampled high at an edge): s1_valid=0, s2_valid=0, accumulator=0. All outputs 0; o_ready=1 in the cycle after reset. Reset mid-operation discards every in-flight operation with no partial output.
- Operation encoding {i_sel, i_Cin}; Cout is the carry out of the WIDTH-bit sum:
  - 000: A+Cin (transfer / increment)
  - 001: A+B+Cin
  - 010: A+~B+Cin (Cin=1 gives A−B)
  - 011: A+{WIDTH{1}}+Cin (decrement / transfer)
  - 100: A&B
  - 101: A|B
  - 110: A^B
  - 111: ~A
- Logic ops (1xx) ignore Cin and force o_Cout=0, o_ovf=0.
- o_ovf for arithmetic ops = (opA[MSB]==opB'[MSB]) && (G[MSB]!=opA[MSB]), where opB' is the second addend actually used: B, ~B, all-ones, or 0.
- Stage 1: captures i_a/i_b/i_sel/i_Cin/i_use_acc when i_valid && o_ready.
- Stage 2: computes combinationally from stage 1 and registers G, Cout and flags on advance.
- Latency: 2 cycles from input handshake to o_valid with no stall. Throughput: 1 op/cycle.
- Stall rules:
  - adv2 = s1_valid && (!s2_valid || i_ready)
  - o_ready = !s1_valid || adv2 (combinational; no bubble on continuous flow)
- Output stability: while o_valid && !i_ready, all outputs hold.
- o_valid deasserts after a handshake unless a new result advances in the same cycle.
- Accumulator:
  - Written with G on every adv2, for every op.
  - An op with i_use_acc=1 reads the accumulator at its own adv2, so it sees the result of the immediately preceding op with no hazard.
  - o_acc reflects the registered accumulator.
- Simultaneous events:
  - Input handshake plus adv2 in the same cycle: stage 1 reloads, stage 2 reloads.
  - Output handshake plus adv2: new result replaces the old one, o_valid stays 1.
- Width: all arithmetic is done at WIDTH+1 bits; o_Cout is bit WIDTH.

Decomposition:
- Shared package alu_pkg: 3-bit op code constants (OP_TFR, OP_ADD, OP_SUBB, OP_DEC, OP_AND, OP_OR, OP_XOR, OP_NOT) and the flag-struct typedef.
- One natural sub-module: alu_core. It is a purely combinational WIDTH-parametrised ALU producing G, Cout and ovf. alu_pipe owns the pipeline registers, handshake and accumulator.

Test Plan:
- WIDTH=4, A=1111, B=0001, sweep all 16 {sel,Cin}, i_ready=1 -> key expected results:
  - 001/0: G=0000, Cout=1, zero=1, ovf=0
  - 010/1: G=1110, Cout=1
  - 011/0: G=1110, Cout=1
  - 000/1: G=0000, Cout=1
  - 111/x: G=0000, Cout=0
  - Each result appears 2 cycles after its input handshake.
- WIDTH=4, A=0111, B=0001, sel=001 Cin=0 -> G=1000, ovf=1, neg=1, Cout=0.
- Accumulate chain, i_use_acc=1, sel=001, B=0011, Cin=0, 4 back-to-back ops from acc=0 -> G sequence 3,6,9,C; o_acc=C. One result per cycle with no bubbles.
- Backpressure: hold i_ready=0 for 5 cycles with a continuous input stream -> o_ready drops after 2 accepted ops. o_G/flags stay stable. On release, all ops retire in order with none lost or duplicated.
- Reset mid-stream: assert i_rst for 1 cycle with both stages full -> next cycle o_valid=0, o_acc=0, o_ready=1, and no stale result appears afterwards.
- Random regression: 10k random ops with random i_valid/i_ready at WIDTH=8 and WIDTH=16, compared against a scoreboard reference model including the accumulator -> zero mismatches.
